// File: rtl/cla_nonlinear_stage_if.sv
// cla_nonlinear_stage_if
// Purpose: bundles the operand input handshake and the product-term output
//   handshake of cla_nonlinear_stage into one interface.
// Signals:
//   in_valid/in_ready        operand beat handshake (upstream side)
//   a, b, c_in               operands and carry in
//   out_valid/out_ready      product-term beat handshake (downstream side)
//   a_q, b_q, c_in_q         operands aligned with n
//   n                        NNL algebraic-normal-form carry product terms
// Modports:
//   master  the side that drives operands and consumes results
//   slave   the stage itself
interface cla_nonlinear_stage_if #(
  parameter int NBIT = 4,
  parameter int NNL  = 56
);
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            c_in;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] a_q;
  logic [NBIT-1:0] b_q;
  logic            c_in_q;
  logic [NNL-1:0]  n;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, a_q, b_q, c_in_q, n
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, a_q, b_q, c_in_q, n
  );
endinterface

// File: rtl/cla_nonlinear_stage.sv
// cla_nonlinear_stage
// Purpose: nonlinear (AND-product) half of a decomposed 4-bit carry-lookahead
//   adder. Expands every carry c1..c4 into its algebraic-normal-form monomials
//   so the downstream linear_part only has to XOR. Two-register valid/ready
//   pipeline (S1 = operands, S2 = product terms + aligned operands) with
//   per-stage bubble collapsing.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        cla_nonlinear_stage_if.slave (operand in, terms out)
//   chk_err_o  sticky self-check error, present only with CLA_NL_CHECK_EN
// Parameters: NBIT must be 4, NNL must be 56 (2^(NBIT+2) - 4 - NBIT).
// Optional feature macro: CLA_NL_CHECK_EN -- ripple-carry cross-check of the
//   XOR of each product-term group on every S2 load.
module cla_nonlinear_stage #(
  parameter int NBIT = 4,
  parameter int NNL  = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nonlinear_stage_if.slave   bus
`ifdef CLA_NL_CHECK_EN
  ,
  output logic                   chk_err_o
`endif
);

  // Stage 1 registers
  logic            v1_q;
  logic [NBIT-1:0] s1_a_q;
  logic [NBIT-1:0] s1_b_q;
  logic            s1_c_q;

  // Stage 2 registers
  logic            v2_q;
  logic [NNL-1:0]  n_q;
  logic [NBIT-1:0] a_q;
  logic [NBIT-1:0] b_q;
  logic            c_in_q;

  logic            s2_load;
  logic            s1_load;
  logic [NNL-1:0]  n_d;

  // A stage may load whenever it is empty or its contents move on this edge,
  // so bubbles collapse without waiting for out_ready.
  assign s2_load = !v2_q || bus.out_ready;
  assign s1_load = !v1_q || s2_load;

  // Product-term expansion. Group k holds the monomials of carry c(k+1):
  //   [a_k*b_k, a_k*(group k-1 terms...), b_k*(group k-1 terms...)]
  // with group -1 being the single term c_in. Group k has 2^(k+2)-1 terms and
  // starts at n[2^(k+2) - k - 4], i.e. 0, 3, 10, 25.
  genvar gi;
  generate
    for (gi = 0; gi < NBIT; gi++) begin : g_grp
      localparam int TP   = (1 << (gi + 1)) - 1;  // terms in the previous carry
      localparam int BASE = (1 << (gi + 2)) - gi - 4;

      logic [TP-1:0]   prev;
      logic [2*TP:0]   grp;

      if (gi == 0) begin : g_first
        assign prev = s1_c_q;
      end else begin : g_rest
        assign prev = g_grp[gi-1].grp;
      end

      assign grp = {{TP{s1_b_q[gi]}} & prev,
                    {TP{s1_a_q[gi]}} & prev,
                    s1_a_q[gi] & s1_b_q[gi]};
      assign n_d[BASE +: 2*TP+1] = grp;
    end
  endgenerate

`ifdef CLA_NL_CHECK_EN
  // Independent ripple-carry reference for c1..c4, compared with the XOR of
  // each expanded group.
  logic [NBIT:0]   rc;
  logic [NBIT-1:0] grp_x;
  logic            chk_mismatch;
  logic            chk_err_q;

  assign rc[0] = s1_c_q;
  generate
    for (gi = 0; gi < NBIT; gi++) begin : g_chk
      assign rc[gi+1]  = (s1_a_q[gi] & s1_b_q[gi]) | (s1_a_q[gi] & rc[gi]) |
                         (s1_b_q[gi] & rc[gi]);
      assign grp_x[gi] = ^g_grp[gi].grp;
    end
  endgenerate
  assign chk_mismatch = |(rc[NBIT:1] ^ grp_x);
  assign chk_err_o    = chk_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_c_q <= 1'b0;
      v2_q   <= 1'b0;
      n_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_in_q <= 1'b0;
`ifdef CLA_NL_CHECK_EN
      chk_err_q <= 1'b0;
`endif
    end else begin
      if (s1_load) begin
        v1_q <= bus.in_valid;
        // Data only moves on a real transfer; an empty slot keeps old data.
        if (bus.in_valid) begin
          s1_a_q <= bus.a;
          s1_b_q <= bus.b;
          s1_c_q <= bus.c_in;
        end
      end
      if (s2_load) begin
        v2_q <= v1_q;
        if (v1_q) begin
          n_q    <= n_d;
          a_q    <= s1_a_q;
          b_q    <= s1_b_q;
          c_in_q <= s1_c_q;
        end
      end
`ifdef CLA_NL_CHECK_EN
      if (s2_load && v1_q && chk_mismatch) begin
        chk_err_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = v2_q;
  assign bus.n         = n_q;
  assign bus.a_q       = a_q;
  assign bus.b_q       = b_q;
  assign bus.c_in_q    = c_in_q;

endmodule

// File: doc/cla_nonlinear_stage.md
# cla_nonlinear_stage

Pipelined nonlinear (AND-product) stage of the decomposed 4-bit carry-lookahead adder. It sits directly upstream of `linear_part`. It takes operands `a`, `b` and `c_in` and computes the 56 algebraic-normal-form product terms of the carries. It delivers those terms, together with the operands, as one aligned beat, so `linear_part` can reduce them with XOR only. The stage uses a two-register valid/ready pipeline with per-stage bubble collapsing.

## Interface
- NBIT, 4, adder width; only 4 is supported.
- NNL, 56, product-term count, equal to 2^(NBIT+2) − 4 − NBIT; any other value is illegal.
- clk  input  1  single clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operand beat is present.
- in_ready  output  1  the stage accepts a beat this cycle.
- a, b  input  NBIT  operands.
- c_in  input  1  carry in.
- out_valid  output  1  `n` and the forwarded operands are valid.
- out_ready  input  1  the downstream stage accepts the beat.
- a_q, b_q  output  NBIT  operands, aligned with `n`.
- c_in_q  output  1  carry in, aligned with `n`.
- n  output  NNL  product terms feeding `linear_part`.
- chk_err  output  1  sticky self-check error; exists only under the macro.

## Operation
- Carry expansion: c0 = c_in; c(k+1) = a_k·b_k ⊕ a_k·c_k ⊕ b_k·c_k, fully expanded into monomials.
- Term count: carry k+1 has T(k+1) = 2·T(k) + 1 terms, with T(0) = 1, giving 3, 7, 15, 31.
- Group base indices: the c1 group starts at n[0], c2 at n[3], c3 at n[10], c4 (c_out) at n[25].
- Order inside the carry-(k+1) group:
  - first, a_k·b_k;
  - then a_k × each term of the c_k group, in that group's order;
  - then b_k × each term of the c_k group, in that group's order.
  - For c1, the c_k group is the single term c_in, so the order is a0b0, a0·c_in, b0·c_in.
- Invariant: the XOR of each group equals the true carry. All monomials are distinct, so no terms cancel.
- Stage 1 (S1) registers a, b and c_in together with its valid bit v1.
- Stage 2 (S2) registers n, computed from the S1 contents, and forwards a, b, c_in into a_q, b_q, c_in_q, with valid bit v2.
- Handshake:
  - out_valid = v2.
  - S2 loads when v2 = 0 or out_ready = 1.
  - S1 loads when v1 = 0 or S2 loads.
  - in_ready equals the S1 load condition.
  - A bubble in either stage is filled without waiting for out_ready.
- Transfer rule: a transfer happens only on valid && ready. Data registers are not loaded when the incoming valid is 0; v is cleared instead.
- Stall: while out_valid = 1 and out_ready = 0, the outputs hold and are bit-stable.

## Timing
- Latency: 2 cycles from an input handshake to out_valid, with no stalls.
- Throughput: 1 beat per cycle with out_ready held at 1.
- Reset:
  - v1, v2 and out_valid are 0; n, a_q, b_q and c_in_q are all-zero; chk_err is 0.
  - in_ready is 1 combinationally while rst is low after reset.
- Reset mid-operation: in-flight beats are discarded and no partial beat is emitted.
- Simultaneous events: an S2 drain and an S1→S2 move in the same cycle are lossless.
- Full pipeline: a new input is accepted in the same cycle that S2 drains.
- Combinational paths: in_ready depends combinationally on out_ready; no other input-to-output path is combinational.

## Configuration
- CLA_NL_CHECK_EN defined:
  - On each S2 load, the stage recomputes c1..c4 with a ripple-carry adder from the S1 operands and compares each against the XOR of its n group.
  - Any mismatch sets chk_err on the next edge. chk_err is sticky until rst.
- CLA_NL_CHECK_EN undefined: the check logic is absent and chk_err is not a port.

## Test plan
- Reset, then in a=4'hF, b=4'h1, c_in=0 with out_ready=1 -> out_valid after 2 cycles; group XORs c1..c4 = 1,1,1,1; n[0]=1, n[1]=n[2]=0.
- a=0, b=0, c_in=1 -> n all zero, group XORs all 0, c_in_q=1.
- Back-to-back 256×2 exhaustive beats with out_ready=1 -> one output per cycle, in order; XOR(n[25..55]) equals bit 4 of a+b+c_in for every beat; chk_err stays 0 with the macro enabled.
- Stall:
  - Stimulus: 3 beats, out_ready=0 for 5 cycles.
  - Required: in_ready falls after 2 accepted beats; outputs stay bit-stable; beat 3 is accepted the cycle out_ready rises; no loss or duplication.
- Random out_ready and in_valid, 10k beats -> the scoreboard sees every input exactly once, in order; XOR of `linear_part` (s, c_out) fed from the outputs equals a+b+c_in.
- Assert rst while 2 beats are in flight -> out_valid is 0 the same cycle; neither beat appears after release.
